// File: rtl/clarvi_timer_pkg.sv
// Shared definitions for the clarvi machine timer: register map, CTRL bit positions,
// reset constants and the byte-lane merge helper.
package clarvi_timer_pkg;

    typedef enum logic [2:0] {
        REG_CTRL     = 3'd0,
        REG_STATUS   = 3'd1,
        REG_TIME_LO  = 3'd2,
        REG_TIME_HI  = 3'd3,
        REG_CMP_LO   = 3'd4,
        REG_CMP_HI   = 3'd5,
        REG_PRESCALE = 3'd6,
        REG_RSVD     = 3'd7
    } reg_addr_e;

    localparam int          CTRL_EN   = 0;
    localparam int          CTRL_IE   = 1;
    localparam logic [63:0] CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

    // Replace only the byte lanes whose enable is set.
    function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                             input logic [31:0] wr_val,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[i*8 +: 8] = wr_val[i*8 +: 8];
            end else begin
                res[i*8 +: 8] = old_val[i*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/clarvi_avalon_timer_if.sv
// Avalon-MM data-port bundle between the clarvi core (master) and the timer (slave).
interface clarvi_avalon_timer_if #(
    parameter int ADDR_WIDTH = 3
) ();
    logic [ADDR_WIDTH-1:0] avs_timer_address;
    logic [3:0]            avs_timer_byteenable;
    logic                  avs_timer_read;
    logic [31:0]           avs_timer_readdata;
    logic                  avs_timer_readdatavalid;
    logic                  avs_timer_write;
    logic [31:0]           avs_timer_writedata;
    logic                  avs_timer_waitrequest;

    modport master (
        output avs_timer_address, avs_timer_byteenable, avs_timer_read,
               avs_timer_write, avs_timer_writedata,
        input  avs_timer_readdata, avs_timer_readdatavalid, avs_timer_waitrequest
    );

    modport slave (
        input  avs_timer_address, avs_timer_byteenable, avs_timer_read,
               avs_timer_write, avs_timer_writedata,
        output avs_timer_readdata, avs_timer_readdatavalid, avs_timer_waitrequest
    );
endinterface

// File: rtl/clarvi_timer_prescaler.sv
// Prescale counter: runs while enabled and emits a single-cycle tick each time it
// reaches the programmed PRESCALE value, then restarts from zero.
module clarvi_timer_prescaler #(
    parameter int PRESCALE_WIDTH = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      i_en,
    input  logic                      i_clear,
    input  logic [PRESCALE_WIDTH-1:0] i_prescale,
    output logic                      o_tick
);
    logic [PRESCALE_WIDTH-1:0] r_count;
    logic                      w_hit;

    assign w_hit  = (r_count == i_prescale);
    assign o_tick = i_en & w_hit;

    // A PRESCALE write restarts the period even while disabled.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= {PRESCALE_WIDTH{1'b0}};
        end else if (i_clear) begin
            r_count <= {PRESCALE_WIDTH{1'b0}};
        end else if (i_en) begin
            if (w_hit) begin
                r_count <= {PRESCALE_WIDTH{1'b0}};
            end else begin
                r_count <= r_count + {{(PRESCALE_WIDTH-1){1'b0}}, 1'b1};
            end
        end else begin
            r_count <= r_count;
        end
    end
endmodule

// File: rtl/clarvi_avalon_timer.sv
// Machine timer on clarvi's data port: 64-bit TIME/CMP, prescaler, level IRQ and a
// fixed one-cycle read pipeline.
module clarvi_avalon_timer
    import clarvi_timer_pkg::*;
#(
    parameter int                        ADDR_WIDTH     = 3,
    parameter int                        PRESCALE_WIDTH = 16,
    parameter logic [PRESCALE_WIDTH-1:0] RESET_PRESCALE = {PRESCALE_WIDTH{1'b0}}
) (
    input  logic                 clock,
    input  logic                 reset,
    clarvi_avalon_timer_if.slave avs,
    output logic                 ins_irq
);
    logic [1:0]                r_ctrl;
    logic [63:0]               r_time;
    logic [63:0]               r_cmp;
    logic [PRESCALE_WIDTH-1:0] r_prescale;
    logic [31:0]               r_shadow;
    logic [31:0]               r_readdata;
    logic                      r_rdvalid;
    logic                      r_irq;

    logic [ADDR_WIDTH-1:0]     w_addr;
    logic [31:0]               w_addr_ext;
    reg_addr_e                 w_reg;
    logic [31:0]               w_rd_mux;
    logic [31:0]               w_wr_old;
    logic [31:0]               w_wr_val;
    logic                      w_match;
    logic                      w_tick;
    logic                      w_pre_clear;
    logic                      w_wr;
    logic                      w_rd;

    assign w_addr     = avs.avs_timer_address;
    assign w_addr_ext = 32'(w_addr);
    assign w_reg      = (w_addr_ext < 32'd8) ? reg_addr_e'(w_addr_ext[2:0]) : REG_RSVD;
    assign w_wr       = avs.avs_timer_write;
    assign w_rd       = avs.avs_timer_read;
    assign w_match    = (r_time >= r_cmp);
    assign w_pre_clear = w_wr && (w_reg == REG_PRESCALE);

    // Pending response is squashed combinationally when reset lands on its cycle.
    assign avs.avs_timer_readdatavalid = r_rdvalid & ~reset;
    assign avs.avs_timer_readdata      = reset ? 32'd0 : r_readdata;
    assign avs.avs_timer_waitrequest   = 1'b0;
    assign ins_irq                     = r_irq;

    always_comb begin
        w_rd_mux = 32'd0;
        case (w_reg)
            REG_CTRL:     w_rd_mux = {30'd0, r_ctrl};
            REG_STATUS:   w_rd_mux = {31'd0, w_match};
            REG_TIME_LO:  w_rd_mux = r_time[31:0];
            REG_TIME_HI:  w_rd_mux = r_shadow;
            REG_CMP_LO:   w_rd_mux = r_cmp[31:0];
            REG_CMP_HI:   w_rd_mux = r_cmp[63:32];
            REG_PRESCALE: w_rd_mux = 32'(r_prescale);
            default:      w_rd_mux = 32'd0;
        endcase
    end

    always_comb begin
        w_wr_old = 32'd0;
        case (w_reg)
            REG_CTRL:     w_wr_old = {30'd0, r_ctrl};
            REG_TIME_LO:  w_wr_old = r_time[31:0];
            REG_TIME_HI:  w_wr_old = r_time[63:32];
            REG_CMP_LO:   w_wr_old = r_cmp[31:0];
            REG_CMP_HI:   w_wr_old = r_cmp[63:32];
            REG_PRESCALE: w_wr_old = 32'(r_prescale);
            default:      w_wr_old = 32'd0;
        endcase
        w_wr_val = be_merge(w_wr_old, avs.avs_timer_writedata, avs.avs_timer_byteenable);
    end

    clarvi_timer_prescaler #(
        .PRESCALE_WIDTH (PRESCALE_WIDTH)
    ) u_prescaler (
        .clock      (clock),
        .reset      (reset),
        .i_en       (r_ctrl[CTRL_EN]),
        .i_clear    (w_pre_clear),
        .i_prescale (r_prescale),
        .o_tick     (w_tick)
    );

    // Read pipeline, coherent-read shadow and interrupt register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rdvalid  <= 1'b0;
            r_readdata <= 32'd0;
            r_shadow   <= 32'd0;
            r_irq      <= 1'b0;
        end else begin
            r_rdvalid  <= w_rd;
            r_readdata <= w_rd ? w_rd_mux : 32'd0;
            if (w_rd && (w_reg == REG_TIME_LO)) begin
                r_shadow <= r_time[63:32];
            end else begin
                r_shadow <= r_shadow;
            end
            r_irq <= r_ctrl[CTRL_IE] & w_match;
        end
    end

    // Register file; a TIME write takes priority over the tick increment.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ctrl     <= 2'd0;
            r_time     <= 64'd0;
            r_cmp      <= CMP_RESET;
            r_prescale <= RESET_PRESCALE;
        end else begin
            r_ctrl     <= (w_wr && (w_reg == REG_CTRL)) ? w_wr_val[1:0] : r_ctrl;
            r_prescale <= w_pre_clear ? w_wr_val[PRESCALE_WIDTH-1:0] : r_prescale;
            if (w_wr && (w_reg == REG_CMP_LO)) begin
                r_cmp <= {r_cmp[63:32], w_wr_val};
            end else if (w_wr && (w_reg == REG_CMP_HI)) begin
                r_cmp <= {w_wr_val, r_cmp[31:0]};
            end else begin
                r_cmp <= r_cmp;
            end
            if (w_wr && (w_reg == REG_TIME_LO)) begin
                r_time <= {r_time[63:32], w_wr_val};
            end else if (w_wr && (w_reg == REG_TIME_HI)) begin
                r_time <= {w_wr_val, r_time[31:0]};
            end else if (w_tick) begin
                r_time <= r_time + 64'd1;
            end else begin
                r_time <= r_time;
            end
        end
    end
endmodule
